// File: rtl/bram_wide_read_streamer.sv
// Read-side sequencer for wide-read BRAMs: issues rce/ra, captures rq and
// streams it out as OUT_DATA_WIDTH lanes, lane 0 (LSBs) first.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, base_addr, word_count   transfer request (sampled when idle)
//   busy, done        status; done pulses once after the final lane
//   rce, ra, rq       RAM read port (rq valid the cycle after rce)
//   out_valid/out_ready/out_data/out_last   lane stream
//
// Optional macro BRAM_STREAM_PREFETCH_EN adds a one-word hold register so
// the next wide word is fetched while the current one drains.
module bram_wide_read_streamer #(
  parameter int READ_ADDR_WIDTH = 10,
  parameter int READ_DATA_WIDTH = 32,
  parameter int OUT_DATA_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [READ_ADDR_WIDTH-1:0] base_addr,
  input  logic [READ_ADDR_WIDTH:0]   word_count,
  output logic                       busy,
  output logic                       done,
  output logic                       rce,
  output logic [READ_ADDR_WIDTH-1:0] ra,
  input  logic [READ_DATA_WIDTH-1:0] rq,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_DATA_WIDTH-1:0]  out_data,
  output logic                       out_last
);

  localparam int RATIO = READ_DATA_WIDTH / OUT_DATA_WIDTH;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  if (!((RATIO == 1) || (RATIO == 2) || (RATIO == 4)) ||
      (RATIO * OUT_DATA_WIDTH != READ_DATA_WIDTH)) begin : g_bad_ratio
    $error("READ_DATA_WIDTH/OUT_DATA_WIDTH must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t                       state_q, state_d;
  logic [READ_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [READ_ADDR_WIDTH:0]     rem_q, rem_d;
  logic [LW-1:0]                lane_q, lane_d;
  logic [READ_DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                         done_q, done_d;
  logic                         rce_c;
  logic                         accept;
  logic                         last_lane;
  logic                         more_q;

`ifdef BRAM_STREAM_PREFETCH_EN
  logic [READ_DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                         hold_v_q, hold_v_d;
  // pf_q: a prefetch read is in flight, rq carries it this cycle
  logic                         pf_q, pf_d;
  logic                         pf_issue;
`endif

  assign accept    = (state_q == DRAIN) && out_ready;
  assign last_lane = (lane_q == LAST_LANE);

`ifdef BRAM_STREAM_PREFETCH_EN
  // rem only drops when a word is captured, so a word in flight or held
  // still counts as "more to come"
  assign more_q   = (rem_q != '0) || hold_v_q || pf_q;
  assign pf_issue = (state_q == DRAIN) && (lane_q == '0) &&
                    (rem_q != '0) && !hold_v_q && !pf_q;
`else
  assign more_q   = (rem_q != '0);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    rce_c   = 1'b0;
`ifdef BRAM_STREAM_PREFETCH_EN
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    pf_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d  = base_addr;
            rem_d   = word_count;
            state_d = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        rce_c   = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        shift_d = rq;
        lane_d  = '0;
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
`ifdef BRAM_STREAM_PREFETCH_EN
        rce_c = pf_issue;
        // a prefetch issued on the final accept becomes a plain CAPTURE
        pf_d  = pf_issue && !(accept && last_lane);
        if (pf_q) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (!(accept && last_lane)) begin
            hold_d   = rq;
            hold_v_d = 1'b1;
          end
        end
        if (accept) begin
          if (!last_lane) begin
            shift_d = shift_q >> OUT_DATA_WIDTH;
            lane_d  = lane_q + 1'b1;
          end else if (hold_v_q) begin
            shift_d  = hold_q;
            hold_v_d = 1'b0;
            lane_d   = '0;
          end else if (pf_q) begin
            shift_d = rq;
            lane_d  = '0;
          end else if (pf_issue) begin
            state_d = CAPTURE;
          end else if (rem_q != '0) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
`else
        if (accept) begin
          shift_d = shift_q >> OUT_DATA_WIDTH;
          lane_d  = lane_q + 1'b1;
          if (last_lane) begin
            if (rem_q != '0) begin
              state_d = ISSUE;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
`ifdef BRAM_STREAM_PREFETCH_EN
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      pf_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      shift_q <= shift_d;
      done_q  <= done_d;
`ifdef BRAM_STREAM_PREFETCH_EN
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      pf_q     <= pf_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rce       = rce_c;
  assign ra        = rce_c ? addr_q : '0;
  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? shift_q[OUT_DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid && last_lane && !more_q;

endmodule

// File: tb/tb_bram_wide_read_streamer.sv
// Directed bench for bram_wide_read_streamer with a behavioural wide-read
// RAM (narrow word n = 16'h5000|n) and a lane scoreboard.
module tb_bram_wide_read_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic        busy, done, rce;
  logic [9:0]  ra;
  logic [31:0] rq;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  bram_wide_read_streamer #(
    .READ_ADDR_WIDTH(10),
    .READ_DATA_WIDTH(32),
    .OUT_DATA_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .rce       (rce),
    .ra        (ra),
    .rq        (rq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // wide word w holds narrow words 2w (low) and 2w+1 (high)
  always_ff @(posedge clk) begin
    if (rce) begin
      rq <= {16'h5000 | {5'd0, ra, 1'b1},
             16'h5000 | {5'd0, ra, 1'b0}};
    end
  end

  int tests = 0;
  int fails = 0;
  logic [16:0] sb[$];
  int ra_log[$];
  int rce_cnt, done_cnt, done_cyc, cyc;
  int first_v, last_v, run, max_run;
  bit busy_seen, mode_tog, tog, stall_prev;
  logic [15:0] prev_d;
  logic        prev_l;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rce_cnt = 0; done_cnt = 0; done_cyc = -1; cyc = 0;
    first_v = -1; last_v = -1; run = 0; max_run = 0;
    busy_seen = 0; stall_prev = 0; tog = 1;
    ra_log.delete();
  endtask

  task automatic tick();
    logic [16:0] e;
    @(negedge clk);
    cyc++;
    out_ready = mode_tog ? tog : 1'b1;
    tog = ~tog;
    if (rce) begin
      rce_cnt++;
      ra_log.push_back(int'(ra));
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (busy) busy_seen = 1;
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(prev_d));
      chk("stall_last", 32'(out_last), 32'(prev_l));
    end
    if (out_valid) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("lane_data", 32'(out_data), 32'(e[15:0]));
        chk("lane_last", 32'(out_last), 32'(e[16]));
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_d = out_data;
    prev_l = out_last;
  endtask

  task automatic push_exp(input int b, input int c);
    int wa;
    for (int w = 0; w < c; w++) begin
      wa = (b + w) % 1024;
      sb.push_back({1'b0, 16'h5000 | 16'(2 * wa)});
      sb.push_back({w == c - 1, 16'h5000 | 16'(2 * wa + 1)});
    end
  endtask

  task automatic run_xfer(input int b, input int c, input bit tg);
    clr();
    mode_tog = tg;
    push_exp(b, c);
    start = 1'b1;
    base_addr = 10'(b);
    word_count = 11'(c);
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    chk("done_seen", done_cnt, 1);
    tick();
    tick();
    chk("done_single", done_cnt, 1);
    chk("sb_drained", sb.size(), 0);
    chk("rce_pulses", rce_cnt, c);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    out_ready = 1'b1; mode_tog = 0;
    clr();
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rce", 32'(rce), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_ra", 32'(ra), 0);
    chk("rst_data", 32'(out_data), 0);
    rst = 1'b0;
    tick();

    // 1 / 6: base 0, count 4, ready held high
    run_xfer(0, 4, 0);
    chk("t1_latency", first_v, 3);
`ifdef BRAM_STREAM_PREFETCH_EN
    chk("t6_max_run", max_run, 8);
    chk("t6_span", last_v - first_v, 7);
`else
    chk("t6_max_run", max_run, 2);
    chk("t6_span", last_v - first_v, 13);
`endif

    // 2: ready toggling, stall stability checked every cycle
    run_xfer(3, 2, 1);

    // 3: address wrap
    run_xfer(1023, 2, 0);
    chk("t3_ra_n", ra_log.size(), 2);
    if (ra_log.size() == 2) begin
      chk("t3_ra0", ra_log[0], 1023);
      chk("t3_ra1", ra_log[1], 0);
    end

    // 4: zero-length request
    run_xfer(5, 0, 0);
    chk("t4_done_lat", done_cyc, 1);
    chk("t4_busy", 32'(busy_seen), 0);
    chk("t4_valid", first_v, -1);

    // 5: reset in the middle of a drain
    clr();
    mode_tog = 0;
    push_exp(0, 8);
    start = 1'b1; base_addr = '0; word_count = 11'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && !(out_valid && cyc > 4); i++) tick();
    chk("t5_in_drain", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_rce", 32'(rce), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("t5_no_done", done_cnt, 0);
    sb.delete();
    run_xfer(0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
